multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I datapath subset (R-type, lw, sw, beq).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared single-port memory with a req/ready handshake.
- Drives the existing control signal set (branch, alusrc, load, aluops, extnrops, memwrite, regwrite), plus PC/IR enables and the memory address-source select.
- Sits between instruction memory/IR and the datapath. It replaces the combinational decoder in the multi-cycle core.

---
 rtl/multicycle_ctrl_pkg.sv | 77 +++++++
 rtl/multicycle_ctrl_mem_wait_timer.sv | 38 +++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I sequencer: opcodes, ALU op
// classes, immediate extender formats, FSM state encodings and fault codes.
package multicycle_ctrl_pkg;

  // Supported major opcodes (instruction[6:0])
  localparam logic [6:0] OPCODE_R = 7'b0110011;  // R-type ALU
  localparam logic [6:0] OPCODE_I = 7'b0000011;  // lw
  localparam logic [6:0] OPCODE_S = 7'b0100011;  // sw
  localparam logic [6:0] OPCODE_B = 7'b1100011;  // beq

  // ALU op classes handed to the ALU control block
  localparam logic [1:0] OPCODE_R_ALU = 2'b10;
  localparam logic [1:0] OPCODE_I_ALU = 2'b00;
  localparam logic [1:0] OPCODE_S_ALU = 2'b00;
  localparam logic [1:0] OPCODE_B_ALU = 2'b01;

  // Immediate extender formats
  localparam logic [1:0] EXTNR_R = 2'd0;
  localparam logic [1:0] EXTNR_I = 2'd1;
  localparam logic [1:0] EXTNR_S = 2'd2;
  localparam logic [1:0] EXTNR_B = 2'd3;

  // FSM state encodings
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  // Fault codes
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  // Datapath controls held constant from EXEC through WB
  typedef struct packed {
    logic       branch;
    logic       alusrc;
    logic [1:0] aluops;
    logic [1:0] extnrops;
  } dp_ctrl_t;

  function automatic logic is_supported(input logic [6:0] op);
    return (op == OPCODE_R) || (op == OPCODE_I) ||
           (op == OPCODE_S) || (op == OPCODE_B);
  endfunction

  function automatic dp_ctrl_t decode_dp(input logic [6:0] op);
    dp_ctrl_t c;
    c = '0;
    case (op)
      OPCODE_R: begin
        c.aluops   = OPCODE_R_ALU;
        c.extnrops = EXTNR_R;
      end
      OPCODE_I: begin
        c.alusrc   = 1'b1;
        c.aluops   = OPCODE_I_ALU;
        c.extnrops = EXTNR_I;
      end
      OPCODE_S: begin
        c.alusrc   = 1'b1;
        c.aluops   = OPCODE_S_ALU;
        c.extnrops = EXTNR_S;
      end
      OPCODE_B: begin
        c.branch   = 1'b1;
        c.aluops   = OPCODE_B_ALU;
        c.extnrops = EXTNR_B;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter: counts request cycles without mem_ready and flags
// when the count has reached MEM_TIMEOUT. MEM_TIMEOUT = 0 never flags.
module multicycle_ctrl_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, otherwise hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (MEM_TIMEOUT > 0) && (cnt_q == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I subset (R-type, lw, sw, beq).
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared
// single-port memory and drives the datapath control set from state + op_q.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_branch,
  output logic       branch,
  output logic       alusrc,
  output logic       load,
  output logic [1:0] aluops,
  output logic [1:0] extnrops,
  output logic       regwrite,
  output logic       retire,
  output logic       fault,
  output logic [1:0] fault_code
);

  logic [2:0] state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [1:0] code_q, code_d;
  // Low for the first cycle after reset so no access is issued in that cycle
  logic       armed_q, armed_d;
  logic       timeout;
  logic       wait_inc;
  dp_ctrl_t   dp;

  assign dp       = decode_dp(op_q);
  assign wait_inc = mem_req && !mem_ready && !timeout;

  multicycle_ctrl_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!wait_inc),
    .inc    (wait_inc),
    .timeout(timeout)
  );

  // Next-state and output decode from the registered state and op_q
  always_comb begin
    // NOTE: every output and next-state gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    code_d     = code_q;
    armed_d    = 1'b1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_branch  = 1'b0;
    branch     = 1'b0;
    alusrc     = 1'b0;
    load       = 1'b0;
    aluops     = 2'b00;
    extnrops   = 2'b00;
    regwrite   = 1'b0;
    retire     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (armed_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
          end else if (timeout) begin
            state_d = ST_FAULT;
            code_d  = FAULT_TIMEOUT;
          end
        end
      end

      ST_DECODE: begin
        op_d = opcode;
        if (is_supported(opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FAULT;
          code_d  = FAULT_ILLEGAL;
        end
      end

      ST_EXEC: begin
        branch   = dp.branch;
        alusrc   = dp.alusrc;
        aluops   = dp.aluops;
        extnrops = dp.extnrops;
        case (op_q)
          OPCODE_R: state_d = ST_WB;
          OPCODE_I,
          OPCODE_S: state_d = ST_MEM;
          OPCODE_B: begin
            pc_branch = zero;
            retire    = 1'b1;
            state_d   = ST_FETCH;
          end
          default: begin
            state_d = ST_FAULT;
            code_d  = FAULT_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        branch   = dp.branch;
        alusrc   = dp.alusrc;
        aluops   = dp.aluops;
        extnrops = dp.extnrops;
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_we   = (op_q == OPCODE_S);
        if (mem_ready) begin
          if (op_q == OPCODE_S) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
          code_d  = FAULT_TIMEOUT;
        end
      end

      ST_WB: begin
        branch   = dp.branch;
        alusrc   = dp.alusrc;
        aluops   = dp.aluops;
        extnrops = dp.extnrops;
        regwrite = 1'b1;
        load     = (op_q == OPCODE_I);
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

  // State, latched opcode and fault code registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      code_q  <= FAULT_NONE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      code_q  <= code_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a fixed R-type vector table,
// directed multi-cycle corner cases and a randomized instruction stream.
// Expected outputs come from an instruction-level model that expands each
// instruction into its per-cycle output trace.
module tb_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_ILL = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_branch;
  logic       branch, alusrc, load, regwrite, retire, fault;
  logic [1:0] aluops, extnrops, fault_code;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_branch;
    logic       branch;
    logic       alusrc;
    logic       load;
    logic [1:0] aluops;
    logic [1:0] extnrops;
    logic       regwrite;
    logic       retire;
    logic       fault;
    logic [1:0] fault_code;
  } outs_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    outs_t      exp;
  } vec_t;

  outs_t act;
  vec_t  q[$];
  vec_t  table_r[4];
  int    checks = 0;
  int    errors = 0;
  int    step = 0;

  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_branch, branch,
                alusrc, load, aluops, extnrops, regwrite, retire, fault, fault_code};

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_branch(pc_branch), .branch(branch), .alusrc(alusrc),
    .load(load), .aluops(aluops), .extnrops(extnrops), .regwrite(regwrite),
    .retire(retire), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %05h expected %05h", name, step, got, exp);
    end
  endtask

  // Controls the spec assigns per instruction class for EXEC..WB
  function automatic outs_t class_ctrl(input logic [6:0] op);
    outs_t o;
    o = '0;
    case (op)
      OP_R:   o.aluops = 2'b10;
      OP_LW:  begin o.alusrc = 1'b1; o.extnrops = 2'd1; end
      OP_SW:  begin o.alusrc = 1'b1; o.extnrops = 2'd2; end
      OP_BEQ: begin o.branch = 1'b1; o.aluops = 2'b01; o.extnrops = 2'd3; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input logic [6:0] op, input logic z, input logic rdy, input outs_t e);
    vec_t v;
    v.opcode = op; v.zero = z; v.mem_ready = rdy; v.exp = e;
    q.push_back(v);
  endtask

  // Waiting cycles of one access; beyond MEM_TIMEOUT waits the access times out
  task automatic push_waits(input logic [6:0] op, input int waits, input outs_t e,
                            output bit timed_out);
    int n;
    n = (waits > MEM_TIMEOUT) ? MEM_TIMEOUT + 1 : waits;
    for (int i = 0; i < n; i++) push(op, 1'($urandom), 1'b0, e);
    timed_out = (waits > MEM_TIMEOUT);
  endtask

  task automatic push_fault(input logic [6:0] op, input logic [1:0] code, input int n);
    outs_t e;
    e = '0; e.fault = 1'b1; e.fault_code = code;
    for (int i = 0; i < n; i++) push(op, 1'($urandom), 1'($urandom), e);
  endtask

  // Expand one instruction into its expected cycle-by-cycle trace
  task automatic add_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
    outs_t e, m;
    bit    to;
    e = '0; e.mem_req = 1'b1;
    push_waits(op, fw, e, to);
    if (to) begin push_fault(op, 2'b10, 10); return; end
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(op, z, 1'b1, e);
    push(op, z, 1'($urandom), '0);                       // decode
    if (!(op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ)) begin
      push_fault(op, 2'b01, 10);
      return;
    end
    e = class_ctrl(op);
    if (op == OP_BEQ) begin
      e.pc_branch = z; e.retire = 1'b1;
      push(op, z, 1'($urandom), e);
      return;
    end
    push(op, z, 1'($urandom), e);                        // exec
    if (op != OP_R) begin
      m = e; m.mem_req = 1'b1; m.iord = 1'b1; m.mem_we = (op == OP_SW);
      push_waits(op, mw, m, to);
      if (to) begin push_fault(op, 2'b10, 10); return; end
      m.retire = (op == OP_SW);
      push(op, z, 1'b1, m);
      if (op == OP_SW) return;
    end
    e.regwrite = 1'b1; e.load = (op == OP_LW); e.retire = 1'b1;
    push(op, z, 1'($urandom), e);                        // writeback
  endtask

  task automatic apply(input vec_t v, input string name);
    @(posedge clk);
    #1;
    opcode = v.opcode; zero = v.zero; mem_ready = v.mem_ready;
    #2;
    step++;
    check(name, act, v.exp);
  endtask

  task automatic run_queue(input string name, input int limit);
    int n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      apply(q.pop_front(), name);
      n++;
    end
  endtask

  // One reset edge; the following cycle must show every output low
  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    #2;
    check(name, act, '0);
    q.delete();
  endtask

  initial begin
    outs_t e;
    logic [6:0] ops[4];
    ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;

    // R-type, zero-wait memory
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    table_r[0] = '{opcode: OP_R, zero: 1'b0, mem_ready: 1'b1, exp: e};
    table_r[1] = '{opcode: OP_R, zero: 1'b0, mem_ready: 1'b1, exp: '0};
    e = '0; e.aluops = 2'b10;
    table_r[2] = '{opcode: OP_R, zero: 1'b1, mem_ready: 1'b1, exp: e};
    e.regwrite = 1'b1; e.retire = 1'b1;
    table_r[3] = '{opcode: OP_R, zero: 1'b0, mem_ready: 1'b1, exp: e};

    do_reset("reset_state");
    for (int i = 0; i < 4; i++) apply(table_r[i], "rtype_table");

    // lw with two wait cycles on fetch and data; sw; beq taken and not taken
    add_instr(OP_LW, 1'b0, 2, 2);   run_queue("lw_wait2", 1000);
    add_instr(OP_SW, 1'b0, 0, 1);   run_queue("sw", 1000);
    add_instr(OP_BEQ, 1'b1, 0, 0);  run_queue("beq_taken", 1000);
    add_instr(OP_BEQ, 1'b0, 1, 0);  run_queue("beq_not_taken", 1000);

    // Illegal opcode: sticky fault, then reset clears it
    add_instr(OP_ILL, 1'b0, 0, 0);  run_queue("illegal_op", 1000);
    do_reset("reset_clears_illegal");

    // Fetch timeout, then ready arriving exactly at the limit
    add_instr(OP_R, 1'b0, MEM_TIMEOUT + 1, 0);  run_queue("fetch_timeout", 1000);
    do_reset("reset_clears_timeout");
    add_instr(OP_R, 1'b0, MEM_TIMEOUT, 0);      run_queue("ready_at_limit", 1000);
    add_instr(OP_LW, 1'b0, 0, MEM_TIMEOUT);     run_queue("lw_ready_at_limit", 1000);
    add_instr(OP_LW, 1'b0, 0, MEM_TIMEOUT + 1); run_queue("data_timeout", 1000);
    do_reset("reset_after_data_timeout");

    // Reset during the data wait of a sw, then a clean instruction
    add_instr(OP_SW, 1'b0, 0, 6);
    run_queue("sw_before_reset", 5);
    do_reset("reset_mid_sw");
    add_instr(OP_R, 1'b0, 0, 0);    run_queue("after_mid_reset", 1000);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      int r, fw, mw;
      r  = int'($urandom_range(0, 7));
      fw = (r == 7) ? MEM_TIMEOUT : int'($urandom_range(0, 3));
      mw = (r == 6) ? MEM_TIMEOUT : int'($urandom_range(0, 3));
      add_instr(ops[$urandom_range(0, 3)], 1'($urandom), fw, mw);
      run_queue("random", 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
